tt_um_taghreed_eialsalman_logic_tester: RTL and testbench

//  Initiator side of the 3-input logic-function interface. The function under test is F = (A&B) | ~C.
//  On start, steps all 8 {C,B,A} vectors: drives each on uio_out[2:0], waits a settle window,

---
 rtl/tt_logic_tester_pkg.sv | 21 ++
 rtl/tt_sync_ff.sv | 25 ++
 rtl/tt_um_taghreed_eialsalman_logic_tester.sv | 118 +++++++++++
 tb/tb_tt_um_taghreed_eialsalman_logic_tester.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tt_logic_tester_pkg.sv
// Shared types and constants for the 3-input logic-function tester.
// The golden truth table is F = (A&B) | ~C, with bit i holding vector i = {C,B,A}.
package tt_logic_tester_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [7:0] GOLDEN_MASK = 8'h8F;
    localparam int VEC_W = 3;
    localparam int CNT_W = 4;

    function automatic logic golden_f(input logic [VEC_W-1:0] vec);
        return (vec[0] & vec[1]) | ~vec[2];
    endfunction

endpackage

// File: rtl/tt_sync_ff.sv
// Generic multi-flop synchroniser for asynchronous pad inputs.
// The enable freezes the chain along with the rest of the design.
module tt_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else if (ena) begin
            chain <= (chain << 1) | STAGES'(d);
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/tt_um_taghreed_eialsalman_logic_tester.sv
// Initiator that walks all eight {C,B,A} vectors, samples the returned F
// and scores it against the golden truth table.
module tt_um_taghreed_eialsalman_logic_tester
    import tt_logic_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t             state;
    logic [VEC_W-1:0]   vec;
    logic [VEC_W-1:0]   vec_out;
    logic [CNT_W-1:0]   settle_cnt;
    logic [3:0]         mismatch;
    logic               start_sync;
    logic               start_prev;
    logic               start_pulse;
    logic               resp_sync;
    logic               resp;
    logic               busy;
    logic               done;
    logic [7:0]         golden;
    logic               unused;

    assign unused = ^{uio_in, ui_in[7:4]};
    assign golden = GOLDEN_MASK;

    tt_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_start (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .d     (ui_in[0]),
        .q     (start_sync)
    );

    tt_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_resp (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .d     (ui_in[1]),
        .q     (resp_sync)
    );

    assign start_pulse = start_sync & ~start_prev;

    // Internal loopback model; fault_inject corrupts it for self-test.
    assign resp = ui_in[2] ? (golden_f(vec) ^ ui_in[3]) : resp_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            vec_out    <= '0;
            settle_cnt <= '0;
            mismatch   <= '0;
            start_prev <= 1'b0;
        end else if (ena) begin
            start_prev <= start_sync;
            unique case (state)
                IDLE, DONE: begin
                    if (start_pulse) begin
                        vec      <= '0;
                        mismatch <= '0;
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    vec_out    <= vec;
                    settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                SAMPLE: begin
                    if (resp != golden[vec] && mismatch != 4'd8) begin
                        mismatch <= mismatch + 4'd1;
                    end
                    if (vec == VEC_W'(7)) begin
                        state <= DONE;
                    end else begin
                        vec   <= vec + 1'b1;
                        state <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == DRIVE) || (state == SETTLE) || (state == SAMPLE);
    assign done = (state == DONE);

    assign uo_out = {
        mismatch,
        done & (mismatch != 4'd0),
        done & (mismatch == 4'd0),
        done,
        busy
    };

    assign uio_out = {5'b0, vec_out};
    assign uio_oe  = 8'b0000_0111;

endmodule

// File: tb/tb_tt_um_taghreed_eialsalman_logic_tester.sv
// Directed bench with a cycle-level behavioural model of the tester.
module tb_tt_um_taghreed_eialsalman_logic_tester;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b1;
    logic       fault = 1'b0;
    logic       force4 = 1'b0;
    logic       resp_in;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_fail = 0;
    bit checking = 0;

    // Model state: phase k within a 48-cycle run, displayed vector, mismatches
    bit m_run = 0;
    int m_k = 0;
    int m_mism = 0;
    int m_vec = 0;
    int en_edges = 0;
    int start_go = -1;

    always #5 clk = ~clk;

    function automatic bit f_ref(input int v);
        bit a, b, c;
        a = v[0];
        b = v[1];
        c = v[2];
        return (a && b) || !c;
    endfunction

    function automatic bit miss(input int v);
        bit r;
        if (mode) r = f_ref(v) ^ fault;
        else r = (force4 && v == 4) ? 1'b1 : f_ref(v);
        return r != f_ref(v);
    endfunction

    assign resp_in = f_ref(int'(uio_out[2:0])) | (force4 && uio_out[2:0] == 3'd4);
    assign ui_in = {4'b0, fault, mode, resp_in, start};
    assign uio_in = 8'h00;

    tt_um_taghreed_eialsalman_logic_tester dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0;
            m_k = 0;
            m_mism = 0;
            m_vec = 0;
            en_edges = 0;
            start_go = -1;
        end else if (ena) begin
            en_edges++;
            if (m_run && m_k < 48) begin
                m_k++;
                if (m_k % 6 == 1) m_vec = m_k / 6;
                if (m_k % 6 == 0) begin
                    m_mism += int'(miss(m_k / 6 - 1));
                    if (m_mism > 8) m_mism = 8;
                end
            end else if (en_edges == start_go) begin
                m_run = 1;
                m_k = 0;
                m_mism = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            logic busy_e, done_e;
            logic [7:0] uo_e;
            busy_e = m_run && m_k < 48;
            done_e = m_run && m_k >= 48;
            uo_e = {4'(m_mism), done_e && m_mism != 0, done_e && m_mism == 0, done_e, busy_e};
            chk("uo_out", uo_out, uo_e);
            chk("uio_out", uio_out, {29'b0, 3'(m_vec)});
            chk("uio_oe", uio_oe, 8'h07);
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        start_go = en_edges + 3;
        repeat (3) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_measure(input int restart_at, input int freeze_at, output int n);
        int guard;
        n = 0;
        guard = 0;
        pulse_start();
        chk("first_busy_uo", uo_out, 8'h01);
        while (uo_out[0] && guard < 200) begin
            if (n == restart_at) begin
                start = 1'b1;
                start_go = en_edges + 3;
            end
            if (n == restart_at + 3) start = 1'b0;
            if (n == freeze_at) ena = 1'b0;
            if (n == freeze_at + 20) ena = 1'b1;
            @(negedge clk);
            n++;
            guard++;
        end
        if (guard >= 200) chk("busy_timeout", 1, 0);
    endtask

    initial begin
        int n;
        bit seen;
        repeat (3) @(negedge clk);
        chk("reset_uo", uo_out, 8'h00);
        chk("reset_uio", uio_out, 8'h00);
        chk("reset_oe", uio_oe, 8'h07);
        rst_n = 1'b1;
        checking = 1;
        repeat (4) @(negedge clk);

        // Internal model, no fault
        mode = 1'b1;
        fault = 1'b0;
        run_measure(-10, -30, n);
        chk("t1_busy_len", n, 48);
        chk("t1_uo", uo_out, 8'h06);
        chk("t1_last_vec", uio_out, 8'h07);

        // Fault inject: all eight vectors wrong
        fault = 1'b1;
        run_measure(-10, -30, n);
        chk("t2_busy_len", n, 48);
        chk("t2_uo", uo_out, 8'h8A);

        // External response, vector 4 forced high
        mode = 1'b0;
        fault = 1'b0;
        force4 = 1'b1;
        run_measure(-10, -30, n);
        chk("t3_busy_len", n, 48);
        chk("t3_uo", uo_out, 8'h1A);

        // Restart from DONE with a second start mid-run
        mode = 1'b1;
        force4 = 1'b0;
        run_measure(10, -30, n);
        chk("t4_busy_len", n, 48);
        chk("t4_uo", uo_out, 8'h06);

        // Enable low for 20 cycles mid-run
        fault = 1'b1;
        run_measure(-10, 15, n);
        chk("t6_busy_len", n, 68);
        chk("t6_uo", uo_out, 8'h8A);

        // Async reset during SETTLE of vector 5
        fault = 1'b0;
        pulse_start();
        n = 0;
        while (n < 32 && uo_out[0]) begin
            @(negedge clk);
            n++;
        end
        chk("t5_pre_vec", uio_out, 8'h05);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_uo", uo_out, 8'h00);
        chk("t5_rst_uio", uio_out, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (uo_out != 8'h00 || uio_out != 8'h00) seen = 1;
        end
        chk("t5_idle_after", 32'(seen), 0);

        checking = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
